// File: rtl/wrr_pkt_arbiter.sv
// Purpose: weighted round-robin packet arbiter; locks a grant for whole packets, up to a per-port packet quota.
// Latency: one cycle from request (or end-of-packet) to registered grant; back-to-back grants with no bubble.
// Backpressure: requesters hold req until granted; grant is held until end-of-packet of the granted port.
module wrr_pkt_arbiter #(
    parameter  int N  = 4,
    parameter  int WW = 3,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_id,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [WW-1:0]  cnt;
    logic [WW-1:0]  q;

    logic [IW-1:0]  next_port;
    logic [IW-1:0]  search_start;
    logic           found;
    logic [IW-1:0]  win;
    logic [WW-1:0]  win_weight;
    logic [WW-1:0]  win_quota;
    logic           eop;
    logic           keep_port;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Port after the granted one, with an explicit wrap so any N works.
    always_comb begin
        next_port = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
    end

    // Round-robin search: from ptr when idle, from the port after the current one at end-of-packet
    // (which naturally leaves the current port last in the order).
    always_comb begin
        int idx;
        idx          = 0;
        found        = 1'b0;
        win          = '0;
        search_start = (state == IDLE) ? ptr : next_port;
        for (int k = 0; k < N; k++) begin
            idx = int'(search_start) + k;
            if (idx > N - 1) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Quota of the winning port; a zero weight still allows one packet.
    always_comb begin
        win_weight = weight[int'(win)*WW +: WW];
        win_quota  = (win_weight == '0) ? WW'(1) : win_weight;
    end

    // End-of-packet is the granted port's last marker; the port keeps the grant only if it still
    // has data and its quota is not yet used up.
    always_comb begin
        eop       = (state == LOCK) && last[grant_id];
        keep_port = req[grant_id] && (({1'b0, cnt} + (WW + 1)'(1)) < {1'b0, q});
    end

    // Grant FSM with registered outputs, pointer, quota and packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= LOCK;
                        grant    <= onehot(win);
                        grant_id <= win;
                        busy     <= 1'b1;
                        q        <= win_quota;
                        cnt      <= '0;
                    end
                end
                LOCK: begin
                    if (eop) begin
                        if (keep_port) begin
                            cnt <= cnt + WW'(1);
                        end else begin
                            ptr <= next_port;
                            cnt <= '0;
                            if (found) begin
                                grant    <= onehot(win);
                                grant_id <= win;
                                q        <= win_quota;
                            end else begin
                                state    <= IDLE;
                                grant    <= '0;
                                grant_id <= '0;
                                busy     <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wrr_pkt_arbiter.md
WRR_PKT_ARBITER -- requirements
Module: wrr_pkt_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..16, any value, not restricted to powers of two).
REQ-002 SHALL have parameter WW, default 3, width of each per-port weight field.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  N  per-port request; port i holds req[i] high while it has data.
REQ-006 SHALL have port last  input  N  per-port end-of-packet marker, qualified by req[i] & grant[i].
REQ-007 SHALL have port weight  input  N*WW  per-port packet quota; field i occupies bits [i*WW +: WW].
REQ-008 SHALL have port grant  output  N  registered one-hot grant (all-zero when idle).
REQ-009 SHALL have port grant_id  output  $clog2(N)  registered index of the granted port, valid while busy=1.
REQ-010 SHALL have port busy  output  1  registered; high while any grant is held.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (grant=0) and LOCK (exactly one grant bit set).
REQ-012 SHALL define a transfer on port i as req[i] & grant[i] in a cycle, and end-of-packet (EOP) as a transfer with last[i]=1.
REQ-013 In IDLE, if any req is set in cycle t, SHALL select a winner by round-robin search from ptr upward, wrapping from N-1 to 0, and assert grant/grant_id/busy at t+1 (one-cycle latency). If no req is set, it SHALL stay in IDLE.
REQ-014 In LOCK, SHALL hold grant unchanged until EOP of the granted port, regardless of other requests or deassertion of req[i] mid-packet.
REQ-015 SHALL sample weight[i] into the quota register q when port i is granted from IDLE or from another port. The value 0 SHALL be treated as 1.
REQ-016 SHALL keep a packet counter cnt (WW bits), cleared to 0 on each new grant and incremented on each EOP of the granted port.
REQ-017 On EOP in cycle t, with req[i]=1 and cnt+1 < q, SHALL keep grant on port i at t+1 with no bubble, and cnt SHALL increment.
REQ-018 On EOP in cycle t otherwise, SHALL set ptr = (i+1) mod N and re-arbitrate in the same cycle from (i+1) mod N. Port i is eligible only last in the search order.
REQ-019 Under REQ-018, a new winner SHALL be granted at t+1 with no bubble. If no req is set, the FSM SHALL go to IDLE at t+1 with grant=0.
REQ-020 A port whose req[i] is already low at EOP SHALL be skipped in the search.
REQ-021 ptr SHALL update only on quota exhaustion or on leaving port i per REQ-018, never during a packet.
REQ-022 The ptr wrap SHALL be explicit (compare with N-1), so that non-power-of-two N is correct.
REQ-023 grant SHALL never have more than one bit set, and grant_id SHALL always equal the index of the set bit.
REQ-024 last[j] for a non-granted port j SHALL be ignored.

Reset
REQ-025 While rst_n=0, SHALL force asynchronously: grant=0, grant_id=0, busy=0, FSM=IDLE, ptr=0, cnt=0, q=0.
REQ-026 Reset asserted mid-packet SHALL abort the lock with no residual state. After release, arbitration SHALL restart from port 0 on the first rising edge with req set.

Verification
REQ-027 Reset check: assert rst_n=0 mid-packet with grant=0100 -> grant=0000 and busy=0 immediately, with no clock required. After release with req=1111 -> grant=0001 one cycle later.
REQ-028 Round-robin check: N=4, weight=1 for all ports, req=1111 held, last=1111 -> grant sequence 0001, 0010, 0100, 1000, 0001, ... with no idle cycles.
REQ-029 Weight check: weight[0]=3, weight[1]=1, req=0011, every transfer EOP -> grant pattern 0001, 0001, 0001, 0010, then repeat.
REQ-030 Packet lock check: port 0 granted with a 5-beat packet (last on beat 5), req[2] raised on beat 2 -> grant stays 0001 through beat 5, then grant=0100 on the next cycle.
REQ-031 Wrap and non-power-of-two check: N=3, ptr=2, req=011, EOP on port 2 -> grant=001. Also drop req[i] mid-packet -> grant held until EOP.
REQ-032 Idle return check: single requester port 1, weight=2, req falls with second EOP -> busy=0 and grant=0 on the next cycle, and ptr=2.
